// File: rtl/alarm_pkg.sv
// alarm_pkg: channel states, edit steps and field encodings shared by the multi-channel alarm
package alarm_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_RINGING = 2'd2;
  localparam state_t ST_SNOOZED = 2'd3;
  localparam logic [31:0] STEP_SEC  = 32'd1;
  localparam logic [31:0] STEP_MIN  = 32'd60;
  localparam logic [31:0] STEP_HOUR = 32'd3600;
  localparam logic [31:0] STEP_DAY  = 32'd86400;
  localparam logic [3:0] FIELD_SEC  = 4'b0001;
  localparam logic [3:0] FIELD_MIN  = 4'b0010;
  localparam logic [3:0] FIELD_HOUR = 4'b0100;
  localparam logic [3:0] FIELD_DAY  = 4'b1000;
  localparam int MODE_ALARM_BIT = 1;
  function automatic logic [31:0] field_step(input logic [3:0] selected);
    return (selected == FIELD_SEC)  ? STEP_SEC  :
           (selected == FIELD_MIN)  ? STEP_MIN  :
           (selected == FIELD_HOUR) ? STEP_HOUR :
           (selected == FIELD_DAY)  ? STEP_DAY  : 32'd0;
  endfunction
endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one alarm time with its arm/ring/snooze FSM, snooze wake time and ring timeout
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int TIME_W         = 28,
  parameter int SNOOZE_S       = 300,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3,
  parameter int DAILY_REPEAT   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TIME_W-1:0] t_main,
  input  logic              tick_1hz,
  input  logic              arm_toggle,
  input  logic              load,
  input  logic              inc,
  input  logic              dec,
  input  logic [31:0]       step,
  input  logic              dismiss,
  input  logic              snooze,
  output logic [TIME_W-1:0] t_alarm,
  output logic              active,
  output logic              ringing
);
  localparam int SW = (TIME_W > 32 ? TIME_W : 32) + 1;
  localparam int CW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int TW = (RING_TIMEOUT_S > 0) ? $clog2(RING_TIMEOUT_S + 2) : 1;
  localparam logic [TIME_W-1:0] T_MAX = '1;

  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] a, input logic [31:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s > SW'(T_MAX)) ? T_MAX : s[TIME_W-1:0];
  endfunction

  function automatic logic [TIME_W-1:0] sat_sub(input logic [TIME_W-1:0] a, input logic [31:0] b);
    return (SW'(a) < SW'(b)) ? '0 : TIME_W'(SW'(a) - SW'(b));
  endfunction

  state_t            state_q, state_d;
  logic [TIME_W-1:0] t_alarm_q, t_alarm_d, wake_q, wake_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              editable, snooze_now, end_ring;

  assign editable   = (state_q == ST_IDLE) || (state_q == ST_ARMED);
  // a ring timeout is treated exactly like a snooze press
  assign snooze_now = !dismiss && (snooze || (timer_q >= TW'(RING_TIMEOUT_S)));
  assign end_ring   = dismiss || (snooze_now && (cnt_q >= CW'(MAX_SNOOZE)));

  always_comb begin
    state_d   = state_q;
    t_alarm_d = (editable && inc) ? sat_add(t_alarm_q, step) :
                (editable && dec) ? sat_sub(t_alarm_q, step) :
                (state_q == ST_IDLE && load) ? t_main : t_alarm_q;
    wake_d    = wake_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (arm_toggle) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (arm_toggle) state_d = ST_IDLE;
        else if (t_main >= t_alarm_q) begin
          state_d = ST_RINGING;
          timer_d = '0;
        end
      end
      ST_RINGING: begin
        timer_d = tick_1hz ? timer_q + TW'(1) : timer_q;
        if (end_ring) begin
          state_d   = (DAILY_REPEAT != 0) ? ST_ARMED : ST_IDLE;
          t_alarm_d = (DAILY_REPEAT != 0) ? sat_add(t_alarm_q, STEP_DAY) : t_alarm_q;
          cnt_d     = '0;
          timer_d   = '0;
        end else if (snooze_now) begin
          state_d = ST_SNOOZED;
          wake_d  = sat_add(t_main, 32'(SNOOZE_S));
          cnt_d   = cnt_q + CW'(1);
          timer_d = '0;
        end
      end
      default: begin
        if (arm_toggle) state_d = ST_IDLE;
        else if (t_main >= wake_q) begin
          state_d = ST_RINGING;
          timer_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      t_alarm_q <= '0;
      wake_q    <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      t_alarm_q <= t_alarm_d;
      wake_q    <= wake_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
    end
  end

  assign t_alarm = t_alarm_q;
  assign active  = state_q != ST_IDLE;
  assign ringing = state_q == ST_RINGING;
endmodule

// File: rtl/multi_alarm.sv
// multi_alarm: NUM_ALARMS independent alarm channels sharing the button inputs and one buzzer
module multi_alarm
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS     = 4,
  parameter int TIME_W         = 28,
  parameter int SNOOZE_S       = 300,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3,
  parameter int DAILY_REPEAT   = 0,
  localparam int CSW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [TIME_W-1:0]     t_main,
  input  logic                  tick_1hz,
  input  logic [2:0]            mode,
  input  logic                  change_mode,
  input  logic                  startstop,
  input  logic                  increment,
  input  logic                  decrement,
  input  logic                  snooze,
  input  logic [3:0]            selected,
  input  logic [CSW-1:0]        ch_sel,
  output logic [TIME_W-1:0]     t_alarm_sel,
  output logic [NUM_ALARMS-1:0] alarm_active,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  timer_buzzer
);
  logic              alarm_mode, ch_valid, sn, inc, dec, cm, unused_mode;
  logic [31:0]       step;
  logic [TIME_W-1:0] t_alarm_w [NUM_ALARMS];

  assign alarm_mode  = mode[MODE_ALARM_BIT];
  assign unused_mode = ^{mode[2], mode[0]};
  assign ch_valid    = 32'(ch_sel) < 32'(NUM_ALARMS);
  // one button per cycle: startstop > snooze > increment > decrement > change_mode
  assign sn   = snooze && !startstop;
  assign inc  = increment && !startstop && !snooze;
  assign dec  = decrement && !startstop && !snooze && !increment;
  assign cm   = change_mode && !startstop && !snooze && !increment && !decrement;
  assign step = field_step(selected);

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    logic hit;
    assign hit = alarm_mode && ch_valid && (ch_sel == CSW'(g));
    alarm_channel #(
      .TIME_W(TIME_W), .SNOOZE_S(SNOOZE_S), .RING_TIMEOUT_S(RING_TIMEOUT_S),
      .MAX_SNOOZE(MAX_SNOOZE), .DAILY_REPEAT(DAILY_REPEAT)
    ) u_ch (
      .clk(clk), .reset_n(reset_n), .t_main(t_main), .tick_1hz(tick_1hz),
      .arm_toggle(startstop && hit), .load(cm && hit), .inc(inc && hit), .dec(dec && hit),
      .step(step), .dismiss(startstop), .snooze(sn),
      .t_alarm(t_alarm_w[g]), .active(alarm_active[g]), .ringing(ringing[g])
    );
  end

  always_comb begin
    t_alarm_sel = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (ch_valid && ch_sel == CSW'(i)) t_alarm_sel = t_alarm_w[i];
  end

  assign timer_buzzer = |ringing;
endmodule

// File: tb/tb_multi_alarm.sv
// tb_multi_alarm: directed scenario tests for multi_alarm, with and without daily repeat
module tb_multi_alarm;
  logic        clk = 1'b0, reset_n = 1'b0, tick_1hz = 1'b0;
  logic [27:0] t_main = '0;
  logic [2:0]  mode = '0;
  logic        change_mode = 1'b0, startstop = 1'b0, increment = 1'b0, decrement = 1'b0, snooze = 1'b0;
  logic [3:0]  selected = '0;
  logic [1:0]  ch_sel = '0;
  logic [27:0] t_alarm_sel, t_alarm_sel_dr;
  logic [3:0]  alarm_active, ringing, alarm_active_dr, ringing_dr;
  logic        timer_buzzer, timer_buzzer_dr;
  int checks = 0, failures = 0;

  localparam logic [4:0] B_SS = 5'b00001, B_SN = 5'b00010, B_INC = 5'b00100, B_DEC = 5'b01000, B_CM = 5'b10000;
  localparam logic [27:0] T_MAX = 28'hFFFFFFF;

  always #5 clk = ~clk;

  multi_alarm #(.DAILY_REPEAT(0)) dut (
    .clk(clk), .reset_n(reset_n), .t_main(t_main), .tick_1hz(tick_1hz), .mode(mode),
    .change_mode(change_mode), .startstop(startstop), .increment(increment), .decrement(decrement),
    .snooze(snooze), .selected(selected), .ch_sel(ch_sel), .t_alarm_sel(t_alarm_sel),
    .alarm_active(alarm_active), .ringing(ringing), .timer_buzzer(timer_buzzer)
  );

  multi_alarm #(.DAILY_REPEAT(1)) dut_dr (
    .clk(clk), .reset_n(reset_n), .t_main(t_main), .tick_1hz(tick_1hz), .mode(mode),
    .change_mode(change_mode), .startstop(startstop), .increment(increment), .decrement(decrement),
    .snooze(snooze), .selected(selected), .ch_sel(ch_sel), .t_alarm_sel(t_alarm_sel_dr),
    .alarm_active(alarm_active_dr), .ringing(ringing_dr), .timer_buzzer(timer_buzzer_dr)
  );

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [4:0] b);
    {change_mode, decrement, increment, snooze, startstop} = b;
    cyc();
    {change_mode, decrement, increment, snooze, startstop} = 5'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mode = 3'b000;
    cyc(2);
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    t_main = 28'd500;
    cyc(2);
    checks++; if (alarm_active !== 4'b0) begin failures++; $display("FAIL reset_active got=%b exp=0000", alarm_active); end
    checks++; if (ringing !== 4'b0) begin failures++; $display("FAIL reset_ringing got=%b exp=0000", ringing); end
    checks++; if (timer_buzzer !== 1'b0) begin failures++; $display("FAIL reset_buzzer got=%b exp=0", timer_buzzer); end
    checks++; if (t_alarm_sel !== 28'd0) begin failures++; $display("FAIL reset_t_alarm got=%0d exp=0", t_alarm_sel); end
    reset_n = 1'b1;
    cyc(2);
    checks++; if (alarm_active !== 4'b0) begin failures++; $display("FAIL reset_release_active got=%b exp=0000", alarm_active); end
  endtask

  task automatic test_arm_ring();
    do_reset();
    t_main = 28'd1000; mode = 3'b010; ch_sel = 2'd0; selected = 4'b0010;
    press(B_CM);
    press(B_INC);
    checks++; if (t_alarm_sel !== 28'd1060) begin failures++; $display("FAIL arm_t_alarm got=%0d exp=1060", t_alarm_sel); end
    press(B_SS);
    checks++; if (alarm_active !== 4'b0001) begin failures++; $display("FAIL arm_active got=%b exp=0001", alarm_active); end
    t_main = 28'd1059;
    cyc();
    checks++; if (ringing !== 4'b0000) begin failures++; $display("FAIL arm_early_ring got=%b exp=0000", ringing); end
    t_main = 28'd1060;
    cyc();
    checks++; if (ringing !== 4'b0001) begin failures++; $display("FAIL arm_ringing got=%b exp=0001", ringing); end
    checks++; if (timer_buzzer !== 1'b1) begin failures++; $display("FAIL arm_buzzer got=%b exp=1", timer_buzzer); end
    mode = 3'b001;
    press(B_SS);
    checks++; if (alarm_active !== 4'b0000) begin failures++; $display("FAIL dismiss_active got=%b exp=0000", alarm_active); end
    checks++; if (timer_buzzer !== 1'b0) begin failures++; $display("FAIL dismiss_buzzer got=%b exp=0", timer_buzzer); end
    checks++; if (alarm_active_dr !== 4'b0001) begin failures++; $display("FAIL daily_rearm_active got=%b exp=0001", alarm_active_dr); end
    checks++; if (t_alarm_sel_dr !== 28'd87460) begin failures++; $display("FAIL daily_rearm_t_alarm got=%0d exp=87460", t_alarm_sel_dr); end
  endtask

  task automatic test_saturation();
    do_reset();
    mode = 3'b010; ch_sel = 2'd1; selected = 4'b0010;
    t_main = 28'd30;
    press(B_CM);
    press(B_DEC);
    checks++; if (t_alarm_sel !== 28'd0) begin failures++; $display("FAIL sat_dec_below got=%0d exp=0", t_alarm_sel); end
    t_main = 28'd60;
    press(B_CM);
    press(B_DEC);
    checks++; if (t_alarm_sel !== 28'd0) begin failures++; $display("FAIL sat_dec_equal got=%0d exp=0", t_alarm_sel); end
    t_main = 28'd100; selected = 4'b0001;
    press(B_CM);
    press(B_INC | B_DEC);
    checks++; if (t_alarm_sel !== 28'd101) begin failures++; $display("FAIL prio_inc_over_dec got=%0d exp=101", t_alarm_sel); end
    selected = 4'b0011;
    press(B_INC);
    checks++; if (t_alarm_sel !== 28'd101) begin failures++; $display("FAIL bad_field got=%0d exp=101", t_alarm_sel); end
    t_main = T_MAX - 28'd9; selected = 4'b0001;
    press(B_CM);
    for (int i = 0; i < 20; i++) press(B_INC);
    checks++; if (t_alarm_sel !== T_MAX) begin failures++; $display("FAIL sat_inc_sec got=%0d exp=%0d", t_alarm_sel, T_MAX); end
    selected = 4'b1000;
    press(B_INC);
    checks++; if (t_alarm_sel !== T_MAX) begin failures++; $display("FAIL sat_inc_day got=%0d exp=%0d", t_alarm_sel, T_MAX); end
    selected = 4'b0100;
    press(B_DEC);
    checks++; if (t_alarm_sel !== 28'd268431855) begin failures++; $display("FAIL dec_hour got=%0d exp=268431855", t_alarm_sel); end
  endtask

  task automatic test_snooze_limit();
    do_reset();
    mode = 3'b010; ch_sel = 2'd0; t_main = 28'd5000;
    press(B_CM);
    press(B_SS);
    cyc();
    checks++; if (ringing !== 4'b0001) begin failures++; $display("FAIL snz_first_ring got=%b exp=0001", ringing); end
    press(B_SN);
    checks++; if (ringing !== 4'b0000) begin failures++; $display("FAIL snz1_ringing got=%b exp=0000", ringing); end
    checks++; if (alarm_active !== 4'b0001) begin failures++; $display("FAIL snz1_active got=%b exp=0001", alarm_active); end
    t_main = 28'd5299;
    cyc();
    checks++; if (ringing !== 4'b0000) begin failures++; $display("FAIL snz1_early got=%b exp=0000", ringing); end
    t_main = 28'd5300;
    cyc();
    checks++; if (ringing !== 4'b0001) begin failures++; $display("FAIL snz1_wake got=%b exp=0001", ringing); end
    press(B_SN);
    t_main = 28'd5600;
    cyc();
    press(B_SN);
    t_main = 28'd5900;
    cyc();
    checks++; if (ringing !== 4'b0001) begin failures++; $display("FAIL snz3_wake got=%b exp=0001", ringing); end
    checks++; if (t_alarm_sel !== 28'd5000) begin failures++; $display("FAIL snz_t_alarm_kept got=%0d exp=5000", t_alarm_sel); end
    press(B_SN);
    checks++; if (alarm_active !== 4'b0000) begin failures++; $display("FAIL snz_limit_disarm got=%b exp=0000", alarm_active); end
    checks++; if (timer_buzzer !== 1'b0) begin failures++; $display("FAIL snz_limit_buzzer got=%b exp=0", timer_buzzer); end
  endtask

  task automatic test_timeout();
    do_reset();
    mode = 3'b010; ch_sel = 2'd2; t_main = 28'd7000;
    press(B_CM);
    press(B_SS);
    cyc();
    checks++; if (ringing !== 4'b0100) begin failures++; $display("FAIL to_ring got=%b exp=0100", ringing); end
    for (int i = 0; i < 59; i++) begin
      tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    end
    checks++; if (ringing !== 4'b0100) begin failures++; $display("FAIL to_59_ticks got=%b exp=0100", ringing); end
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    checks++; if (ringing !== 4'b0000) begin failures++; $display("FAIL to_60_ticks got=%b exp=0000", ringing); end
    checks++; if (alarm_active !== 4'b0100) begin failures++; $display("FAIL to_snoozed_active got=%b exp=0100", alarm_active); end
    t_main = 28'd7299;
    cyc();
    checks++; if (ringing !== 4'b0000) begin failures++; $display("FAIL to_wake_early got=%b exp=0000", ringing); end
    t_main = 28'd7300;
    cyc();
    checks++; if (ringing !== 4'b0100) begin failures++; $display("FAIL to_wake got=%b exp=0100", ringing); end
    press(B_SN);
    t_main = 28'd7600;
    cyc();
    press(B_SN);
    t_main = 28'd7900;
    cyc();
    checks++; if (ringing !== 4'b0100) begin failures++; $display("FAIL to_third_ring got=%b exp=0100", ringing); end
    press(B_SN);
    checks++; if (alarm_active !== 4'b0000) begin failures++; $display("FAIL to_count_one got=%b exp=0000", alarm_active); end
  endtask

  task automatic test_multi_priority();
    do_reset();
    mode = 3'b010; t_main = 28'd9000;
    ch_sel = 2'd0; press(B_CM);
    ch_sel = 2'd3; press(B_CM);
    t_main = 28'd8000;
    ch_sel = 2'd0; press(B_SS);
    ch_sel = 2'd3; press(B_SS);
    checks++; if (alarm_active !== 4'b1001) begin failures++; $display("FAIL multi_armed got=%b exp=1001", alarm_active); end
    t_main = 28'd9000;
    cyc();
    checks++; if (ringing !== 4'b1001) begin failures++; $display("FAIL multi_ringing got=%b exp=1001", ringing); end
    checks++; if (timer_buzzer !== 1'b1) begin failures++; $display("FAIL multi_buzzer got=%b exp=1", timer_buzzer); end
    ch_sel = 2'd0; selected = 4'b0001;
    press(B_INC);
    checks++; if (t_alarm_sel !== 28'd9000) begin failures++; $display("FAIL ring_edit_ignored got=%0d exp=9000", t_alarm_sel); end
    mode = 3'b001;
    press(B_SS | B_SN);
    checks++; if (alarm_active !== 4'b0000) begin failures++; $display("FAIL multi_dismiss got=%b exp=0000", alarm_active); end
    checks++; if (timer_buzzer !== 1'b0) begin failures++; $display("FAIL multi_dismiss_buzzer got=%b exp=0", timer_buzzer); end
    checks++; if (alarm_active_dr !== 4'b1001) begin failures++; $display("FAIL multi_daily_active got=%b exp=1001", alarm_active_dr); end
    checks++; if (ringing_dr !== 4'b0000) begin failures++; $display("FAIL multi_daily_ringing got=%b exp=0000", ringing_dr); end
    checks++; if (t_alarm_sel_dr !== 28'd95400) begin failures++; $display("FAIL multi_daily_ch0 got=%0d exp=95400", t_alarm_sel_dr); end
    ch_sel = 2'd3;
    #1;
    checks++; if (t_alarm_sel_dr !== 28'd95400) begin failures++; $display("FAIL multi_daily_ch3 got=%0d exp=95400", t_alarm_sel_dr); end
  endtask

  task automatic test_reset_mid_ring();
    do_reset();
    mode = 3'b010; ch_sel = 2'd1; t_main = 28'd100;
    press(B_CM);
    press(B_SS);
    cyc();
    checks++; if (ringing !== 4'b0010) begin failures++; $display("FAIL rst_ring_pre got=%b exp=0010", ringing); end
    reset_n = 1'b0;
    cyc();
    checks++; if (timer_buzzer !== 1'b0) begin failures++; $display("FAIL rst_ring_buzzer got=%b exp=0", timer_buzzer); end
    checks++; if (alarm_active !== 4'b0000) begin failures++; $display("FAIL rst_ring_active got=%b exp=0000", alarm_active); end
    checks++; if (t_alarm_sel !== 28'd0) begin failures++; $display("FAIL rst_ring_t_alarm got=%0d exp=0", t_alarm_sel); end
    reset_n = 1'b1;
    cyc(3);
    checks++; if (ringing !== 4'b0000) begin failures++; $display("FAIL rst_no_rering got=%b exp=0000", ringing); end
  endtask

  initial begin
    test_reset();
    test_arm_ring();
    test_saturation();
    test_snooze_limit();
    test_timeout();
    test_multi_priority();
    test_reset_mid_ring();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
